// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BHT/BTB with 2-bit saturating
// counters, trained by the resolved branch outcome from ID.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   if_pc             - fetch PC; pred_taken/pred_target predict its next PC
//   id_*              - ID-stage instruction, its resolved outcome, and the
//                       prediction that travelled with it from IF
//   mispredict        - flush IF/ID and redirect fetch to redirect_pc
//   br_count          - resolved branches retired through ID
//   mispred_count     - mispredictions signalled
module branch_predictor #(
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned TAG_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        id_valid,
  input  logic        id_stall,
  input  logic        id_is_branch,
  input  logic [31:0] id_pc,
  input  logic        id_taken,
  input  logic [31:0] id_target,
  input  logic        id_pred_taken,
  input  logic [31:0] id_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int unsigned ENTRIES = 1 << INDEX_W;
  localparam int unsigned IDX_LO  = 2;
  localparam int unsigned IDX_HI  = INDEX_W + 1;
  localparam int unsigned TAG_LO  = INDEX_W + 2;
  localparam int unsigned TAG_HI  = INDEX_W + TAG_W + 1;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
  } entry_t;

  entry_t tbl_q [ENTRIES];

  logic [INDEX_W-1:0] if_idx;
  logic [TAG_W-1:0]   if_tag;
  logic               if_hit;
  logic [INDEX_W-1:0] id_idx;
  logic [TAG_W-1:0]   id_tag;
  logic               id_hit;
  logic               upd;
  logic               wrong_branch;
  logic               wrong_nonbranch;

  // Zero-latency prediction from the pre-update table contents
  always_comb begin
    if_idx      = if_pc[IDX_HI:IDX_LO];
    if_tag      = if_pc[TAG_HI:TAG_LO];
    if_hit      = tbl_q[if_idx].valid && (tbl_q[if_idx].tag == if_tag);
    pred_taken  = if_hit && tbl_q[if_idx].ctr[1];
    pred_target = pred_taken ? tbl_q[if_idx].target : if_pc + 32'd4;
  end

  // Resolution in ID: lookup for training and mispredict detection
  always_comb begin
    id_idx          = id_pc[IDX_HI:IDX_LO];
    id_tag          = id_pc[TAG_HI:TAG_LO];
    id_hit          = tbl_q[id_idx].valid && (tbl_q[id_idx].tag == id_tag);
    upd             = id_valid && !id_stall;
    wrong_branch    = id_is_branch &&
                      ((id_taken != id_pred_taken) ||
                       (id_taken && (id_target != id_pred_target)));
    // A non-branch predicted taken means the entry aliased onto it
    wrong_nonbranch = !id_is_branch && id_pred_taken;
    mispredict      = upd && (wrong_branch || wrong_nonbranch);
    redirect_pc     = (id_is_branch && id_taken) ? id_target : id_pc + 32'd4;
  end

  // Table training, alias cleanup and performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tbl_q[i].valid  <= 1'b0;
        tbl_q[i].tag    <= '0;
        tbl_q[i].target <= '0;
        tbl_q[i].ctr    <= 2'b01;
      end
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (upd && id_is_branch) begin
        br_count <= br_count + 32'd1;
        if (id_hit) begin
          if (id_taken) begin
            if (tbl_q[id_idx].ctr != 2'b11) tbl_q[id_idx].ctr <= 2'(tbl_q[id_idx].ctr + 2'd1);
            tbl_q[id_idx].target <= id_target;
          end else if (tbl_q[id_idx].ctr != 2'b00) begin
            tbl_q[id_idx].ctr <= 2'(tbl_q[id_idx].ctr - 2'd1);
          end
        end else if (id_taken) begin
          tbl_q[id_idx] <= '{valid: 1'b1, tag: id_tag, target: id_target, ctr: 2'b10};
        end
      end else if (upd && id_pred_taken && id_hit) begin
        tbl_q[id_idx].valid <= 1'b0;
      end
      if (mispredict) mispred_count <= mispred_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus a
// randomized back-to-back run, checked against a queue-based scoreboard.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        id_valid, id_stall, id_is_branch, id_taken, id_pred_taken;
  logic [31:0] id_pc, id_target, id_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc, br_count, mispred_count;

  int pass_cnt = 0;
  int total    = 0;

  typedef struct {
    logic        mp;
    logic [31:0] rpc;
  } exp_t;
  exp_t sb[$];

  // Reference model of the table and counters
  logic        mv   [64];
  logic [7:0]  mtag [64];
  logic [31:0] mtgt [64];
  logic [1:0]  mctr [64];
  logic [31:0] m_br, m_mp;

  branch_predictor dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .id_valid(id_valid), .id_stall(id_stall), .id_is_branch(id_is_branch),
    .id_pc(id_pc), .id_taken(id_taken), .id_target(id_target),
    .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  function automatic logic [5:0] m_idx(input logic [31:0] pc);
    return pc[7:2];
  endfunction

  function automatic logic [7:0] m_tg(input logic [31:0] pc);
    return pc[15:8];
  endfunction

  function automatic logic m_hit(input logic [31:0] pc);
    return mv[m_idx(pc)] && (mtag[m_idx(pc)] == m_tg(pc));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      mv[i] = 1'b0; mtag[i] = '0; mtgt[i] = '0; mctr[i] = 2'b01;
    end
    m_br = '0;
    m_mp = '0;
  endtask

  task automatic model_pred(input logic [31:0] pc, output logic t, output logic [31:0] tgt);
    t   = m_hit(pc) && mctr[m_idx(pc)][1];
    tgt = t ? mtgt[m_idx(pc)] : pc + 32'd4;
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    logic upd, a, b;
    upd   = id_valid && !id_stall;
    a     = id_is_branch && ((id_taken != id_pred_taken) ||
                             (id_taken && (id_target != id_pred_target)));
    b     = !id_is_branch && id_pred_taken;
    e.mp  = upd && (a || b);
    e.rpc = (id_is_branch && id_taken) ? id_target : id_pc + 32'd4;
    return e;
  endfunction

  task automatic model_update();
    exp_t e;
    logic [5:0] i;
    e = model_expect();
    i = m_idx(id_pc);
    if (e.mp) m_mp = m_mp + 32'd1;
    if (id_valid && !id_stall) begin
      if (id_is_branch) begin
        m_br = m_br + 32'd1;
        if (m_hit(id_pc)) begin
          if (id_taken) begin
            if (mctr[i] != 2'b11) mctr[i] = mctr[i] + 2'd1;
            mtgt[i] = id_target;
          end else if (mctr[i] != 2'b00) begin
            mctr[i] = mctr[i] - 2'd1;
          end
        end else if (id_taken) begin
          mv[i] = 1'b1; mtag[i] = m_tg(id_pc); mtgt[i] = id_target; mctr[i] = 2'b10;
        end
      end else if (id_pred_taken && m_hit(id_pc)) begin
        mv[i] = 1'b0;
      end
    end
  endtask

  // Drive an ID-stage instruction at the falling edge and queue its expectation
  task automatic drive_id(input logic br, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic ptk,
                          input logic [31:0] ptgt, input logic stall);
    @(negedge clk);
    id_valid = 1'b1; id_stall = stall; id_is_branch = br; id_pc = pc;
    id_taken = tk; id_target = tgt; id_pred_taken = ptk; id_pred_target = ptgt;
    sb.push_back(model_expect());
    #1;
  endtask

  // Let the rising edge consume the ID inputs, then retire them
  task automatic commit();
    @(posedge clk);
    model_update();
    #1;
    id_valid = 1'b0; id_stall = 1'b0; id_is_branch = 1'b0; id_pred_taken = 1'b0;
  endtask

  task automatic set_if(input logic [31:0] pc);
    @(negedge clk);
    if_pc = pc;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_pc = 32'h100;
    id_valid = 0; id_stall = 0; id_is_branch = 0; id_pc = 0; id_taken = 0;
    id_target = 0; id_pred_taken = 0; id_pred_target = 0;
    model_reset();
    #12;
    total++;
    if (pred_taken !== 1'b0) $display("FAIL reset_pred_taken: got %b want 0", pred_taken);
    else pass_cnt++;
    total++;
    if (pred_target !== 32'h104) $display("FAIL reset_pred_target: got %h want 00000104", pred_target);
    else pass_cnt++;
    total++;
    if (br_count !== 32'd0 || mispred_count !== 32'd0)
      $display("FAIL reset_counters: got br=%0d mp=%0d want 0/0", br_count, mispred_count);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_taken();
    exp_t e;
    drive_id(1, 32'h100, 1, 32'h80, 0, 32'h104, 0);
    e = sb.pop_front();
    total++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h80 || mispredict !== e.mp || redirect_pc !== e.rpc)
      $display("FAIL first_taken_mispredict: got mp=%b rpc=%h want mp=1 rpc=00000080", mispredict, redirect_pc);
    else pass_cnt++;
    commit();
    set_if(32'h100);
    total++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80)
      $display("FAIL first_taken_pred: got %b/%h want 1/00000080", pred_taken, pred_target);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      drive_id(1, 32'h100, 1, 32'h80, 1, 32'h80, 0);
      e = sb.pop_front();
      total++;
      if (mispredict !== e.mp || mispredict !== 1'b0)
        $display("FAIL sat_taken_%0d: got mp=%b want 0", k, mispredict);
      else pass_cnt++;
      commit();
    end
    // 11 -> 10: still taken, but this resolution was a mispredict
    drive_id(1, 32'h100, 0, 32'h80, 1, 32'h80, 0);
    e = sb.pop_front();
    total++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h104 || redirect_pc !== e.rpc)
      $display("FAIL sat_not_taken: got mp=%b rpc=%h want 1/00000104", mispredict, redirect_pc);
    else pass_cnt++;
    commit();
    set_if(32'h100);
    total++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80)
      $display("FAIL sat_pred_after_nt: got %b/%h want 1/00000080", pred_taken, pred_target);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    exp_t e;
    logic [31:0] br0, mp0;
    br0 = br_count; mp0 = mispred_count;
    for (int k = 0; k < 2; k++) begin
      drive_id(1, 32'h100, 0, 32'h80, 1, 32'h80, 1);
      e = sb.pop_front();
      total++;
      if (mispredict !== 1'b0 || mispredict !== e.mp)
        $display("FAIL stall_mispredict_%0d: got %b want 0", k, mispredict);
      else pass_cnt++;
      commit();
    end
    set_if(32'h100);
    total++;
    if (pred_taken !== 1'b1 || br_count !== br0 || mispred_count !== mp0)
      $display("FAIL stall_no_update: got pt=%b br=%0d mp=%0d want 1/%0d/%0d",
               pred_taken, br_count, mispred_count, br0, mp0);
    else pass_cnt++;
    drive_id(1, 32'h100, 0, 32'h80, 1, 32'h80, 0);
    e = sb.pop_front();
    total++;
    if (mispredict !== 1'b1 || mispredict !== e.mp)
      $display("FAIL stall_release_mp: got %b want 1", mispredict);
    else pass_cnt++;
    commit();
    set_if(32'h100);
    total++;
    // 10 -> 01 after exactly one update
    if (pred_taken !== 1'b0 || pred_target !== 32'h104 ||
        br_count !== br0 + 32'd1 || mispred_count !== mp0 + 32'd1)
      $display("FAIL stall_release_once: got pt=%b tgt=%h br=%0d mp=%0d want 0/00000104/%0d/%0d",
               pred_taken, pred_target, br_count, mispred_count, br0 + 32'd1, mp0 + 32'd1);
    else pass_cnt++;
  endtask

  task automatic test_alias();
    exp_t e;
    drive_id(1, 32'h100, 1, 32'h80, 0, 32'h104, 0);
    void'(sb.pop_front());
    commit();
    drive_id(0, 32'h200, 0, 32'h0, 1, 32'h80, 0);
    e = sb.pop_front();
    total++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h204 || redirect_pc !== e.rpc)
      $display("FAIL alias_other_tag: got mp=%b rpc=%h want 1/00000204", mispredict, redirect_pc);
    else pass_cnt++;
    commit();
    set_if(32'h100);
    total++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80)
      $display("FAIL alias_kept: got %b/%h want 1/00000080", pred_taken, pred_target);
    else pass_cnt++;
    drive_id(0, 32'h100, 0, 32'h0, 1, 32'h80, 0);
    e = sb.pop_front();
    total++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h104 || mispredict !== e.mp)
      $display("FAIL alias_same_tag: got mp=%b rpc=%h want 1/00000104", mispredict, redirect_pc);
    else pass_cnt++;
    commit();
    set_if(32'h100);
    total++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104)
      $display("FAIL alias_invalidated: got %b/%h want 0/00000104", pred_taken, pred_target);
    else pass_cnt++;
    total++;
    if (br_count !== m_br || mispred_count !== m_mp)
      $display("FAIL alias_counters: got br=%0d mp=%0d want %0d/%0d", br_count, mispred_count, m_br, m_mp);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [5];
    logic [31:0] pc, tgt, ptgt;
    logic        br, tk, ptk, st, mt;
    logic [31:0] mtg;
    exp_t e;
    pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h104; pcs[3] = 32'h1100; pcs[4] = 32'h3c;
    for (int n = 0; n < 300; n++) begin
      pc  = pcs[$urandom_range(0, 4)];
      br  = ($urandom_range(0, 3) != 0);
      tk  = 1'($urandom_range(0, 1));
      tgt = {22'd0, 8'($urandom_range(0, 3) * 16), 2'b00};
      st  = ($urandom_range(0, 5) == 0);
      model_pred(pc, ptk, ptgt);
      if ($urandom_range(0, 7) == 0) ptk = ~ptk;
      if ($urandom_range(0, 7) == 0) ptgt = ptgt ^ 32'h40;
      drive_id(br, pc, tk, tgt, ptk, ptgt, st);
      // Fetch the same index this cycle: must see pre-update contents
      if_pc = pcs[$urandom_range(0, 4)];
      #1;
      model_pred(if_pc, mt, mtg);
      e = sb.pop_front();
      total++;
      if (mispredict !== e.mp || (e.mp && redirect_pc !== e.rpc))
        $display("FAIL b2b_resolve_%0d: got mp=%b rpc=%h want mp=%b rpc=%h",
                 n, mispredict, redirect_pc, e.mp, e.rpc);
      else pass_cnt++;
      total++;
      if (pred_taken !== mt || pred_target !== mtg)
        $display("FAIL b2b_pred_%0d: pc=%h got %b/%h want %b/%h", n, if_pc, pred_taken, pred_target, mt, mtg);
      else pass_cnt++;
      commit();
      total++;
      if (br_count !== m_br || mispred_count !== m_mp)
        $display("FAIL b2b_counters_%0d: got br=%0d mp=%0d want %0d/%0d", n, br_count, mispred_count, m_br, m_mp);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    drive_id(1, 32'h100, 1, 32'h80, 0, 32'h104, 0);
    void'(sb.pop_front());
    commit();
    drive_id(1, 32'h100, 1, 32'h80, 1, 32'h80, 0);
    void'(sb.pop_front());
    commit();
    set_if(32'h100);
    total++;
    if (pred_taken !== 1'b1 || br_count === 32'd0)
      $display("FAIL areset_precondition: got pt=%b br=%0d want 1/nonzero", pred_taken, br_count);
    else pass_cnt++;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104 || br_count !== 32'd0 || mispred_count !== 32'd0)
      $display("FAIL areset_immediate: got pt=%b tgt=%h br=%0d mp=%0d want 0/00000104/0/0",
               pred_taken, pred_target, br_count, mispred_count);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_taken();
    test_saturate();
    test_stall();
    test_alias();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor: a direct-mapped BHT/BTB with 2-bit saturating counters.
- Supplies a next-PC prediction to IF and is trained by the resolved branch outcome from the ID-stage branch test.
- Detects mispredictions and outputs the redirect PC used to flush IF/ID.
- Keeps running branch and mispredict counters for performance measurement.

Parameters:
- INDEX_W, 6, log2 of table entries (64 entries); index = pc[INDEX_W+1:2].
- TAG_W, 8, tag width; tag = pc[INDEX_W+TAG_W+1:INDEX_W+2].

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  32  PC currently being fetched.
- pred_taken  out  1  prediction for if_pc: taken.
- pred_target  out  32  predicted next PC for if_pc.
- id_valid  in  1  ID stage holds a valid instruction.
- id_stall  in  1  ID stage stalled this cycle; no training, no mispredict.
- id_is_branch  in  1  ID instruction is SB-type.
- id_pc  in  32  PC of the ID instruction.
- id_taken  in  1  resolved branch outcome from the branch test.
- id_target  in  32  resolved branch target (pc + B-immediate).
- id_pred_taken  in  1  pred_taken that travelled with this instruction from IF.
- id_pred_target  in  32  pred_target that travelled with this instruction from IF.
- mispredict  out  1  flush IF/ID and redirect fetch this cycle.
- redirect_pc  out  32  correct next PC when mispredict=1.
- br_count  out  32  resolved branches retired through ID.
- mispred_count  out  32  mispredictions signalled.

Behaviour:
- Entry fields: valid, tag[TAG_W], target[32], ctr[2].
- Reset (async, rst_n=0), cleared immediately regardless of clock:
  - every entry: valid=0, ctr=2'b01;
  - br_count=0, mispred_count=0;
  - combinational outputs follow from cleared state: pred_taken=0, pred_target=if_pc+4.
- Prediction (combinational, zero latency):
  - hit = valid[idx] & tag match;
  - pred_taken = hit & ctr[1];
  - pred_target = pred_taken ? target : if_pc+4.
- Update qualifier: upd = id_valid & ~id_stall. Nothing in the tables or counters changes when upd=0.
- Training, on the clock edge when upd & id_is_branch, using id_pc index/tag:
  - hit, taken: ctr saturating increment (max 2'b11); target <= id_target.
  - hit, not taken: ctr saturating decrement (min 2'b00); target unchanged.
  - miss, taken: allocate/overwrite: valid=1, tag, target=id_target, ctr=2'b10.
  - miss, not taken: no change.
  - br_count <= br_count+1, wrapping at 2^32.
- Alias cleanup: upd & ~id_is_branch & id_pred_taken (non-branch predicted taken) → invalidate the entry at id_pc index if its tag matches.
- mispredict = upd & (A | B):
  - A = id_is_branch & (id_taken != id_pred_taken | (id_taken & id_target != id_pred_target));
  - B = ~id_is_branch & id_pred_taken.
- redirect_pc = (id_is_branch & id_taken) ? id_target : id_pc+4; driven every cycle, meaningful only when mispredict=1.
- mispred_count increments on every clock edge where mispredict=1, wrapping at 2^32.
- Same-cycle read and write to the same index: the prediction uses pre-update contents; no bypass.
- Any stall that holds ID must assert id_stall, so a stalled instruction never trains twice.
- id_pc[1:0] and if_pc[1:0] are ignored.

Test Plan:
- Reset, then if_pc=0x100 → pred_taken=0, pred_target=0x104; br_count=0, mispred_count=0.
- Branch at 0x100 with id_taken=1, id_target=0x80, id_pred_taken=0 → mispredict=1, redirect_pc=0x80. Next cycle if_pc=0x100 → pred_taken=1, pred_target=0x80, ctr=2'b10.
- Same branch taken 3 more times, then not-taken once → ctr goes 11,11,11,10; prediction stays taken; the not-taken resolution gives mispredict=1, redirect_pc=0x104.
- Branch resolved with id_stall=1 → mispredict=0, ctr and counters unchanged. Release the stall → exactly one update.
- Alias: 0x100 and 0x200 share an index (INDEX_W=6); train 0x100 taken. A non-branch at 0x200 with id_pred_taken=1 → mispredict=1, redirect_pc=0x204, and the entry is not invalidated (tag mismatch). The same case at 0x100 invalidates the entry.
- Drop rst_n asynchronously mid-run (between edges) → pred_taken=0 and counters=0 immediately, before the next clk edge.
